// File: rtl/dcache_ctrl.sv
// Data-cache controller: 3-lane load lookup with fill bypass, 4-entry MSHR file
// for miss tracking, single-outstanding-issue memory interface and array fill.
module dcache_ctrl #(
  parameter int MSHR_NUM = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   ld_valid,
  input  logic [2:0][15:0]             ld_addr,
  output logic [2:0]                   ld_hit,
  output logic [2:0][63:0]             ld_data,
  output logic [2:0]                   ld_stall,
  output logic [2:0][4:0]              rd_idx,
  output logic [2:0][7:0]              rd_tag,
  input  logic [2:0][63:0]             rd_data,
  input  logic [2:0]                   rd_valid,
  output logic [2:0]                   wr_en,
  output logic [2:0][4:0]              wr_idx,
  output logic [2:0][7:0]              wr_tag,
  output logic [2:0][63:0]             wr_data,
  output logic [1:0]                   proc2mem_command,
  output logic [15:0]                  proc2mem_addr,
  input  logic [3:0]                   mem2proc_response,
  input  logic [3:0]                   mem2proc_tag,
  input  logic [63:0]                  mem2proc_data,
  output logic                         fill_valid,
  output logic [15:0]                  fill_addr,
  output logic [63:0]                  fill_data,
  output logic [MSHR_NUM-1:0][1:0]     mshr_state
);

  typedef enum logic [1:0] {
    MS_INVALID    = 2'd0,
    MS_WAIT_ISSUE = 2'd1,
    MS_WAIT_MEM   = 2'd2
  } mshr_state_e;

  mshr_state_e st_q  [MSHR_NUM];
  logic [12:0] blk_q [MSHR_NUM];
  logic [3:0]  tag_q [MSHR_NUM];

  logic                iss_any, ret_any;
  logic [1:0]          iss_sel, ret_sel;
  logic [MSHR_NUM-1:0] busy, alloc;
  logic [12:0]         alloc_blk [MSHR_NUM];
  logic [2:0]          lane_bypass;
  logic                merged, found;
  logic [1:0]          free_sel;

  // Offset bits select a byte inside the block; the controller works on whole blocks.
  logic unused_offsets;
  assign unused_offsets = ^{ld_addr[0][2:0], ld_addr[1][2:0], ld_addr[2][2:0]};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rd_idx[i]      = ld_addr[i][7:3];
      rd_tag[i]      = ld_addr[i][15:8];
      lane_bypass[i] = fill_valid && (ld_addr[i][15:3] == fill_addr[15:3]);
      ld_hit[i]      = ld_valid[i] & (rd_valid[i] | lane_bypass[i]);
      ld_data[i]     = lane_bypass[i] ? fill_data : rd_data[i];
    end
  end

  always_comb begin
    iss_any = 1'b0;
    iss_sel = '0;
    ret_any = 1'b0;
    ret_sel = '0;
    for (int e = 0; e < MSHR_NUM; e++) begin
      if (!iss_any && st_q[e] == MS_WAIT_ISSUE) begin
        iss_any = 1'b1;
        iss_sel = 2'(e);
      end
      if (!ret_any && mem2proc_tag != 4'd0 && st_q[e] == MS_WAIT_MEM &&
          tag_q[e] == mem2proc_tag) begin
        ret_any = 1'b1;
        ret_sel = 2'(e);
      end
    end
  end

  // An entry being returned this cycle counts as free, so it can be reused immediately.
  always_comb begin
    alloc    = '0;
    ld_stall = '0;
    merged   = 1'b0;
    found    = 1'b0;
    free_sel = '0;
    for (int e = 0; e < MSHR_NUM; e++) begin
      alloc_blk[e] = '0;
      busy[e]      = (st_q[e] != MS_INVALID) && !(ret_any && ret_sel == 2'(e));
    end
    for (int i = 0; i < 3; i++) begin
      merged   = 1'b0;
      found    = 1'b0;
      free_sel = '0;
      if (ld_valid[i] && !ld_hit[i]) begin
        for (int e = 0; e < MSHR_NUM; e++) begin
          if (busy[e] && blk_q[e] == ld_addr[i][15:3]) merged = 1'b1;
          if (alloc[e] && alloc_blk[e] == ld_addr[i][15:3]) merged = 1'b1;
        end
        for (int e = 0; e < MSHR_NUM; e++) begin
          if (!merged && !found && !busy[e] && !alloc[e]) begin
            found    = 1'b1;
            free_sel = 2'(e);
          end
        end
        if (!merged && found) begin
          alloc[free_sel]     = 1'b1;
          alloc_blk[free_sel] = ld_addr[i][15:3];
        end
        if (!merged && !found) ld_stall[i] = 1'b1;
      end
    end
  end

  // Memory handshake: LOAD on proc2mem_command is the request (valid); a nonzero
  // mem2proc_response in the same cycle is the accept (ready) and carries the tag.
  // Without an accept the request is held unchanged into the next cycle.
  always_comb begin
    proc2mem_command = iss_any ? 2'd1 : 2'd0;
    proc2mem_addr    = iss_any ? {blk_q[iss_sel], 3'b000} : 16'h0000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < MSHR_NUM; e++) begin
        st_q[e]  <= MS_INVALID;
        blk_q[e] <= '0;
        tag_q[e] <= '0;
      end
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
    end else begin
      for (int e = 0; e < MSHR_NUM; e++) begin
        if (alloc[e]) begin
          st_q[e]  <= MS_WAIT_ISSUE;
          blk_q[e] <= alloc_blk[e];
        end else if (iss_any && iss_sel == 2'(e) && mem2proc_response != 4'd0) begin
          st_q[e]  <= MS_WAIT_MEM;
          tag_q[e] <= mem2proc_response;
        end else if (ret_any && ret_sel == 2'(e)) begin
          st_q[e] <= MS_INVALID;
        end
      end
      fill_valid <= ret_any;
      if (ret_any) begin
        fill_addr <= {blk_q[ret_sel], 3'b000};
        fill_data <= mem2proc_data;
      end
    end
  end

  always_comb begin
    wr_en      = {2'b00, fill_valid};
    wr_idx     = '0;
    wr_tag     = '0;
    wr_data    = '0;
    wr_idx[0]  = fill_addr[7:3];
    wr_tag[0]  = fill_addr[15:8];
    wr_data[0] = fill_data;
    for (int e = 0; e < MSHR_NUM; e++) mshr_state[e] = st_q[e];
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl: reset, hits, misses, merging, stalls,
// issue retry, fill bypass and mid-operation reset.
module tb_dcache_ctrl;
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        ld_valid;
  logic [2:0][15:0]  ld_addr;
  logic [2:0]        ld_hit;
  logic [2:0][63:0]  ld_data;
  logic [2:0]        ld_stall;
  logic [2:0][4:0]   rd_idx;
  logic [2:0][7:0]   rd_tag;
  logic [2:0][63:0]  rd_data;
  logic [2:0]        rd_valid;
  logic [2:0]        wr_en;
  logic [2:0][4:0]   wr_idx;
  logic [2:0][7:0]   wr_tag;
  logic [2:0][63:0]  wr_data;
  logic [1:0]        proc2mem_command;
  logic [15:0]       proc2mem_addr;
  logic [3:0]        mem2proc_response;
  logic [3:0]        mem2proc_tag;
  logic [63:0]       mem2proc_data;
  logic              fill_valid;
  logic [15:0]       fill_addr;
  logic [63:0]       fill_data;
  logic [3:0][1:0]   mshr_state;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dcache_ctrl #(.MSHR_NUM(4)) dut (
    .clock(clock), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_stall(ld_stall), .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag),
    .wr_data(wr_data), .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr), .mem2proc_response(mem2proc_response),
    .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .mshr_state(mshr_state)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    ld_valid = '0; ld_addr = '0; rd_valid = '0; rd_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    #1 reset = 1'b0;
    #2;
    checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL rst_fill_valid got=%0h exp=0", fill_valid); end
    checks++; if (fill_addr !== 16'h0) begin failures++; $display("FAIL rst_fill_addr got=%0h exp=0", fill_addr); end
    checks++; if (fill_data !== 64'h0) begin failures++; $display("FAIL rst_fill_data got=%0h exp=0", fill_data); end
    checks++; if (wr_en !== 3'b000) begin failures++; $display("FAIL rst_wr_en got=%0h exp=0", wr_en); end
    checks++; if (proc2mem_command !== 2'd0) begin failures++; $display("FAIL rst_cmd got=%0h exp=0", proc2mem_command); end
    checks++; if (proc2mem_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", proc2mem_addr); end
    checks++; if (mshr_state !== 8'h00) begin failures++; $display("FAIL rst_mshr got=%0h exp=0", mshr_state); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_single_miss;
    do_reset();
    ld_valid = 3'b001; ld_addr[0] = 16'h1238;
    #2;
    checks++; if (ld_hit !== 3'b000) begin failures++; $display("FAIL sm_hit got=%0h exp=0", ld_hit); end
    checks++; if (ld_stall !== 3'b000) begin failures++; $display("FAIL sm_stall got=%0h exp=0", ld_stall); end
    step();
    ld_valid = '0; mem2proc_response = 4'd3;
    #2;
    checks++; if (proc2mem_command !== 2'd1) begin failures++; $display("FAIL sm_cmd got=%0h exp=1", proc2mem_command); end
    checks++; if (proc2mem_addr !== 16'h1238) begin failures++; $display("FAIL sm_addr got=%0h exp=1238", proc2mem_addr); end
    step();
    mem2proc_response = 4'd0;
    #2;
    checks++; if (proc2mem_command !== 2'd0) begin failures++; $display("FAIL sm_cmd_idle got=%0h exp=0", proc2mem_command); end
    step(); step(); step();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEADBEEF;
    step();
    mem2proc_tag = 4'd0; mem2proc_data = '0;
    #2;
    checks++; if (fill_valid !== 1'b1) begin failures++; $display("FAIL sm_fill_valid got=%0h exp=1", fill_valid); end
    checks++; if (wr_en !== 3'b001) begin failures++; $display("FAIL sm_wr_en got=%0h exp=1", wr_en); end
    checks++; if (wr_idx[0] !== 5'd7) begin failures++; $display("FAIL sm_wr_idx got=%0h exp=7", wr_idx[0]); end
    checks++; if (wr_tag[0] !== 8'h12) begin failures++; $display("FAIL sm_wr_tag got=%0h exp=12", wr_tag[0]); end
    checks++; if (wr_data[0] !== 64'hDEADBEEF) begin failures++; $display("FAIL sm_wr_data got=%0h exp=deadbeef", wr_data[0]); end
    checks++; if (fill_addr !== 16'h1238) begin failures++; $display("FAIL sm_fill_addr got=%0h exp=1238", fill_addr); end
    step();
    #2;
    checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL sm_fill_once got=%0h exp=0", fill_valid); end
    checks++; if (wr_en !== 3'b000) begin failures++; $display("FAIL sm_wr_en_once got=%0h exp=0", wr_en); end
  endtask

  task automatic test_hit;
    do_reset();
    ld_valid = 3'b110; ld_addr[1] = 16'h0800; ld_addr[2] = 16'h5555;
    rd_valid = 3'b110; rd_data[1] = 64'h1234_5678; rd_data[2] = 64'hA5A5_0000_FFFF_0001;
    #2;
    checks++; if (ld_hit !== 3'b110) begin failures++; $display("FAIL hit_mask got=%0h exp=6", ld_hit); end
    checks++; if (ld_data[2] !== 64'hA5A5_0000_FFFF_0001) begin failures++; $display("FAIL hit_data2 got=%0h exp=a5a50000ffff0001", ld_data[2]); end
    checks++; if (ld_stall !== 3'b000) begin failures++; $display("FAIL hit_stall got=%0h exp=0", ld_stall); end
    checks++; if (rd_idx[2] !== 5'h0A) begin failures++; $display("FAIL hit_rd_idx got=%0h exp=a", rd_idx[2]); end
    checks++; if (rd_tag[2] !== 8'h55) begin failures++; $display("FAIL hit_rd_tag got=%0h exp=55", rd_tag[2]); end
    step();
    clear_inputs();
    #2;
    checks++; if (mshr_state !== 8'h00) begin failures++; $display("FAIL hit_no_alloc got=%0h exp=0", mshr_state); end
  endtask

  task automatic test_three_lane;
    do_reset();
    ld_valid = 3'b111; ld_addr[0] = 16'h1238; ld_addr[1] = 16'h123C; ld_addr[2] = 16'h4400;
    #2;
    checks++; if (ld_hit !== 3'b000) begin failures++; $display("FAIL tl_hit got=%0h exp=0", ld_hit); end
    checks++; if (ld_stall !== 3'b000) begin failures++; $display("FAIL tl_stall got=%0h exp=0", ld_stall); end
    step();
    ld_valid = '0; mem2proc_response = 4'd1;
    #2;
    checks++; if (mshr_state !== 8'h05) begin failures++; $display("FAIL tl_alloc2 got=%0h exp=5", mshr_state); end
    checks++; if (proc2mem_command !== 2'd1) begin failures++; $display("FAIL tl_cmd1 got=%0h exp=1", proc2mem_command); end
    checks++; if (proc2mem_addr !== 16'h1238) begin failures++; $display("FAIL tl_addr1 got=%0h exp=1238", proc2mem_addr); end
    step();
    mem2proc_response = 4'd2; mem2proc_tag = 4'd1; mem2proc_data = 64'h1111;
    #2;
    checks++; if (proc2mem_command !== 2'd1) begin failures++; $display("FAIL tl_cmd2 got=%0h exp=1", proc2mem_command); end
    checks++; if (proc2mem_addr !== 16'h4400) begin failures++; $display("FAIL tl_addr2 got=%0h exp=4400", proc2mem_addr); end
    step();
    clear_inputs();
    #2;
    checks++; if (proc2mem_command !== 2'd0) begin failures++; $display("FAIL tl_cmd_idle got=%0h exp=0", proc2mem_command); end
    checks++; if (fill_valid !== 1'b1) begin failures++; $display("FAIL tl_fill_valid got=%0h exp=1", fill_valid); end
    checks++; if (fill_addr !== 16'h1238) begin failures++; $display("FAIL tl_fill_addr got=%0h exp=1238", fill_addr); end
    checks++; if (fill_data !== 64'h1111) begin failures++; $display("FAIL tl_fill_data got=%0h exp=1111", fill_data); end
    checks++; if (mshr_state !== 8'h08) begin failures++; $display("FAIL tl_mshr got=%0h exp=8", mshr_state); end
  endtask

  task automatic test_full;
    do_reset();
    ld_valid = 3'b111; ld_addr[0] = 16'h1000; ld_addr[1] = 16'h2000; ld_addr[2] = 16'h3000;
    step();
    ld_valid = 3'b001; ld_addr[0] = 16'h4000;
    #2;
    checks++; if (ld_stall !== 3'b000) begin failures++; $display("FAIL full_stall4 got=%0h exp=0", ld_stall); end
    step();
    ld_valid = 3'b011; ld_addr[0] = 16'h1004; ld_addr[1] = 16'h5000;
    #2;
    checks++; if (mshr_state !== 8'h55) begin failures++; $display("FAIL full_mshr got=%0h exp=55", mshr_state); end
    checks++; if (ld_stall !== 3'b010) begin failures++; $display("FAIL full_stall got=%0h exp=2", ld_stall); end
    checks++; if (ld_hit !== 3'b000) begin failures++; $display("FAIL full_hit got=%0h exp=0", ld_hit); end
    checks++; if (proc2mem_addr !== 16'h1000) begin failures++; $display("FAIL full_addr got=%0h exp=1000", proc2mem_addr); end
    step();
    clear_inputs();
  endtask

  task automatic test_reject_bypass;
    do_reset();
    ld_valid = 3'b001; ld_addr[0] = 16'h1238;
    step();
    ld_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (proc2mem_command !== 2'd1) begin failures++; $display("FAIL rj_cmd%0d got=%0h exp=1", k, proc2mem_command); end
      checks++; if (proc2mem_addr !== 16'h1238) begin failures++; $display("FAIL rj_addr%0d got=%0h exp=1238", k, proc2mem_addr); end
      step();
    end
    mem2proc_response = 4'd5;
    #2;
    checks++; if (mshr_state !== 8'h01) begin failures++; $display("FAIL rj_still_issue got=%0h exp=1", mshr_state); end
    step();
    mem2proc_response = 4'd0; mem2proc_tag = 4'd7; mem2proc_data = 64'hBAD;
    #2;
    checks++; if (mshr_state !== 8'h02) begin failures++; $display("FAIL rj_wait_mem got=%0h exp=2", mshr_state); end
    checks++; if (proc2mem_command !== 2'd0) begin failures++; $display("FAIL rj_cmd_idle got=%0h exp=0", proc2mem_command); end
    step();
    mem2proc_tag = 4'd5; mem2proc_data = 64'hCAFE_F00D;
    #2;
    checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL rj_stray_tag got=%0h exp=0", fill_valid); end
    step();
    mem2proc_tag = 4'd0; mem2proc_data = '0;
    ld_valid = 3'b001; ld_addr[0] = 16'h1238; rd_valid = 3'b000;
    #2;
    checks++; if (ld_hit !== 3'b001) begin failures++; $display("FAIL byp_hit got=%0h exp=1", ld_hit); end
    checks++; if (ld_data[0] !== 64'hCAFE_F00D) begin failures++; $display("FAIL byp_data got=%0h exp=cafef00d", ld_data[0]); end
    checks++; if (ld_stall !== 3'b000) begin failures++; $display("FAIL byp_stall got=%0h exp=0", ld_stall); end
    step();
    clear_inputs();
    #2;
    checks++; if (mshr_state !== 8'h00) begin failures++; $display("FAIL byp_no_alloc got=%0h exp=0", mshr_state); end
    checks++; if (proc2mem_command !== 2'd0) begin failures++; $display("FAIL byp_cmd got=%0h exp=0", proc2mem_command); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    ld_valid = 3'b011; ld_addr[0] = 16'h1238; ld_addr[1] = 16'h4400;
    step();
    ld_valid = '0; mem2proc_response = 4'd3;
    step();
    mem2proc_response = 4'd4;
    step();
    mem2proc_response = 4'd0;
    #2;
    checks++; if (mshr_state !== 8'h0A) begin failures++; $display("FAIL mr_pre got=%0h exp=a", mshr_state); end
    reset = 1'b0;
    #1;
    checks++; if (mshr_state !== 8'h00) begin failures++; $display("FAIL mr_mshr got=%0h exp=0", mshr_state); end
    checks++; if (proc2mem_command !== 2'd0) begin failures++; $display("FAIL mr_cmd got=%0h exp=0", proc2mem_command); end
    checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL mr_fill got=%0h exp=0", fill_valid); end
    step();
    reset = 1'b1; mem2proc_tag = 4'd3; mem2proc_data = 64'h3333;
    step();
    mem2proc_tag = 4'd0;
    #2;
    checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL mr_old_tag got=%0h exp=0", fill_valid); end
    checks++; if (wr_en !== 3'b000) begin failures++; $display("FAIL mr_wr_en got=%0h exp=0", wr_en); end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_hit();
    test_three_lane();
    test_full();
    test_reject_bypass();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Data-cache controller that sits between the load/store queue (LSQ) and the 32-entry direct-mapped `dcache_mem` array. It performs up to three load lookups per cycle against the array. It tracks misses in a 4-entry miss-status holding register (MSHR) file and issues block reads to memory. When memory returns a block, the controller writes it into the array through write port 0 and broadcasts the fill to the LSQ.

## Interface
Parameters:
- `MSHR_NUM`, 4: number of MSHR entries. Fixed at 4; mem tags are 4 bits.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low. Asserted when 0.
- `ld_valid`  in  [2:0]  load lookup request per lane.
- `ld_addr`  in  [2:0][15:0]  byte address per lane. Fields: [15:8] tag, [7:3] idx, [2:0] offset.
- `ld_hit`  out  [2:0]  lane hit. Data is on `ld_data` this cycle.
- `ld_data`  out  [2:0][63:0]  block data for hitting lane.
- `ld_stall`  out  [2:0]  lane missed and no MSHR could be allocated or merged. LSQ retries the load.
- `rd_idx`  out  [2:0][4:0]  to `dcache_mem` read index.
- `rd_tag`  out  [2:0][7:0]  to `dcache_mem` read tag.
- `rd_data`  in  [2:0][63:0]  from `dcache_mem`.
- `rd_valid`  in  [2:0]  from `dcache_mem`. Tag-matched valid.
- `wr_en`  out  [2:0]  to `dcache_mem`. Only bit 0 is ever driven high.
- `wr_idx`  out  [2:0][4:0]  write index. Lanes 1 and 2 are tied to 0.
- `wr_tag`  out  [2:0][7:0]  write tag. Lanes 1 and 2 are tied to 0.
- `wr_data`  out  [2:0][63:0]  write data. Lanes 1 and 2 are tied to 0.
- `proc2mem_command`  out  [1:0]  memory command: 0 NONE, 1 LOAD.
- `proc2mem_addr`  out  [15:0]  block-aligned address, [2:0]=0.
- `mem2proc_response`  in  [3:0]  nonzero means accepted, carrying the transaction tag. 0 means rejected.
- `mem2proc_tag`  in  [3:0]  nonzero means data return for that tag.
- `mem2proc_data`  in  [63:0]  returned block.
- `fill_valid`  out  1  fill broadcast to the LSQ.
- `fill_addr`  out  [15:0]  block-aligned address of the fill.
- `fill_data`  out  [63:0]  filled block.

## Operation
- Lookup is combinational per lane.
  - `rd_idx[i]`=`ld_addr[i][7:3]`; `rd_tag[i]`=`ld_addr[i][15:8]`.
  - `ld_hit[i]` = `ld_valid[i]` & (`rd_valid[i]` | fill bypass).
- Fill bypass: if `fill_valid` and `ld_addr[i][15:3]`==`fill_addr[15:3]`, the lane hits and `ld_data[i]`=`fill_data`. This avoids a duplicate fetch while the array write is in flight.
- Miss handling, resolved in lane order 0, 1, 2 in the same cycle:
  - The lane merges with an existing valid MSHR entry on the same block, or with an entry allocated by a lower lane this cycle. Merged lanes are not stalled.
  - Otherwise the lane allocates the lowest-index INVALID entry, which goes to WAIT_ISSUE.
  - If no entry is free, `ld_stall[i]`=1.
  - Missing lanes get `ld_hit`=0. The LSQ waits for `fill_valid` with a matching block.
- Each MSHR entry has a state (INVALID, WAIT_ISSUE, WAIT_MEM), a block address and a 4-bit mem tag.
- Issue:
  - The lowest-index WAIT_ISSUE entry drives `proc2mem_command`=LOAD and its address.
  - If no entry is in WAIT_ISSUE, the command is NONE.
  - If `mem2proc_response`!=0, the entry goes to WAIT_MEM and stores that tag. If it is 0, the entry stays in WAIT_ISSUE and reissues next cycle.
- Return: if `mem2proc_tag`!=0 and it equals the tag of a WAIT_MEM entry:
  - that entry goes to INVALID;
  - the fill register loads {block addr, `mem2proc_data`}.
  - A tag that matches no entry is ignored.
- Fill register drives, for exactly one cycle per return:
  - `wr_en`=3'b001, with `wr_idx[0]`, `wr_tag[0]`, `wr_data[0]` from the fill register;
  - `fill_valid`=1.
- An entry freed by a return may be reallocated by a miss in the same cycle. A miss to that same block hits via bypass on the following cycle; in the return cycle itself it allocates normally.
- An issue and a return may complete on different entries in the same cycle.

## Timing
- Reset (asynchronous, `reset`=0):
  - All MSHR entries go to INVALID.
  - The fill register is cleared, so `fill_valid`=0, `fill_addr`=0, `fill_data`=0 and `wr_en`=0.
  - `proc2mem_command`=NONE and `proc2mem_addr`=0.
- Mid-operation reset discards all outstanding misses. Later returns for old tags match nothing and are ignored.
- Hit latency is 0 cycles: `ld_hit` and `ld_data` are valid in the request cycle.
- A miss allocated in cycle N issues in N+1 at the earliest.
- Data returned in cycle M appears on `fill_valid`/`wr_en` in cycle M+1. The array shows it as valid from M+2.
- `proc2mem_command` is combinational from registered MSHR state. `mem2proc_response` is sampled in the same cycle.

## Test plan
- Reset, then lane 0 loads 0x1238 with the array empty:
  - cycle 0: `ld_hit`=0, `ld_stall`=0.
  - cycle 1: `proc2mem_command`=1, `proc2mem_addr`=0x1238.
  - Response tag 3 is given. Data 0xDEADBEEF is returned with tag 3 in cycle 5.
  - cycle 6: `fill_valid`=1, `wr_en`=001, `wr_idx[0]`=7, `wr_tag[0]`=0x12.
- All three lanes miss in one cycle on 0x1238, 0x123C and 0x4400:
  - 2 MSHRs are allocated; no stall.
  - Two LOAD commands are issued over successive cycles, for 0x1238 then 0x4400.
- With 4 MSHRs occupied, lane 1 misses on a new block → `ld_stall`=3'b010.
  - A lane on an already-outstanding block merges without stall.
- `mem2proc_response`=0 for 3 cycles → the same LOAD and address are held. When tag 5 is given, the entry moves to WAIT_MEM.
- Load 0x1238 in the cycle when `fill_valid` is set for 0x1238 → `ld_hit`=1, `ld_data`=fill data, and no new MSHR is allocated.
- `reset` pulsed low while 2 misses are outstanding → all outputs return to reset values. A later `mem2proc_tag`=3 gives `fill_valid`=0.
